sram_like_arbiter: RTL

SRAM_LIKE_ARBITER -- requirements
Module: sram_like_arbiter

---
 rtl/sram_like_arbiter_if.sv | 39 +++
 rtl/sram_like_arbiter.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/sram_like_arbiter_if.sv
// ----------------------------------------------------------------------------
// sram_like_arbiter_if
// SRAM-like request/response bundle. One instance per master port and one
// for the shared slave port of sram_like_arbiter.
//
// Signals:
//   req      request valid (held until addr_ok)
//   wr       1 = write, 0 = read
//   size     access size code
//   addr     byte address
//   wdata    write data
//   addr_ok  request accepted this cycle
//   data_ok  response returned this cycle
//   rdata    read data, valid when data_ok=1
//
// Modports:
//   master   side that issues requests (drives req/wr/size/addr/wdata)
//   slave    side that accepts requests (drives addr_ok/data_ok/rdata)
// ----------------------------------------------------------------------------
interface sram_like_arbiter_if;
    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] rdata;

    modport master (
        output req, wr, size, addr, wdata,
        input  addr_ok, data_ok, rdata
    );

    modport slave (
        input  req, wr, size, addr, wdata,
        output addr_ok, data_ok, rdata
    );
endinterface

// File: rtl/sram_like_arbiter.sv
// ----------------------------------------------------------------------------
// sram_like_arbiter
// Merges an instruction master and a data master onto one SRAM-like slave
// port (typically an AXI bridge). One request is in flight on the address
// phase at a time; an order FIFO remembers which master owns each
// outstanding response so data_ok is routed back in issue order.
//
// Parameters:
//   OT_DEPTH   order-FIFO depth, power of 2, >= 2; max outstanding requests
//
// Ports:
//   aclk       clock, rising edge
//   aresetn    asynchronous active-low reset
//   inst       instruction master port (slave modport)
//   data       data master port (slave modport)
//   s          shared downstream port (master modport)
//
// Build option:
//   ARB_ROUND_ROBIN_EN  defined   : round-robin between the two masters,
//                                   first tie after reset goes to data
//                       undefined : fixed priority, data over inst
// ----------------------------------------------------------------------------
//
// state  | meaning
// -------+-----------------------------------------------------------------
// IDLE   | no request on s; arbitrate if the order FIFO has room
// GNT_I  | instruction request driven on s, held until s.addr_ok
// GNT_D  | data request driven on s, held until s.addr_ok
//
module sram_like_arbiter #(
    parameter int OT_DEPTH = 4
) (
    input  logic                aclk,
    input  logic                aresetn,
    sram_like_arbiter_if.slave  inst,
    sram_like_arbiter_if.slave  data,
    sram_like_arbiter_if.master s
);

    localparam int PTR_W = (OT_DEPTH > 1) ? $clog2(OT_DEPTH) : 1;
    localparam int CNT_W = $clog2(OT_DEPTH) + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_I = 2'd1,
        GNT_D = 2'd2
    } state_t;

    state_t             state;

    // Order FIFO: one bit per outstanding request, 0 = inst, 1 = data.
    logic [OT_DEPTH-1:0] order_id;
    logic [PTR_W-1:0]    wr_ptr;
    logic [PTR_W-1:0]    rd_ptr;
    logic [CNT_W-1:0]    count;

    logic fifo_full;
    logic fifo_empty;
    logic push;
    logic pop;
    logic head_id;
    logic any_req;
    logic pick_data;

    assign fifo_full  = (count == CNT_W'(OT_DEPTH));
    assign fifo_empty = (count == '0);
    assign push       = (state != IDLE) && s.addr_ok;
    // A data_ok with nothing outstanding is a slave protocol error; drop it.
    assign pop        = s.data_ok && !fifo_empty;
    assign head_id    = order_id[rd_ptr];
    assign any_req    = inst.req || data.req;

`ifdef ARB_ROUND_ROBIN_EN
    // 1 when data was the most recent grant. Reset value 0 makes the first
    // tie go to data.
    logic last_data;

    always_comb begin
        pick_data = data.req && (!inst.req || !last_data);
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            last_data <= 1'b0;
        end else if (state == IDLE && !fifo_full && any_req) begin
            last_data <= pick_data;
        end
    end
`else
    always_comb begin
        pick_data = data.req;
    end
`endif

    // Arbitration uses the registered count, so a pop in the same cycle does
    // not open a slot until the following cycle.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (!fifo_full && any_req) begin
                        state <= pick_data ? GNT_D : GNT_I;
                    end
                end
                GNT_I, GNT_D: begin
                    if (s.addr_ok) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            order_id <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
        end else begin
            if (push) begin
                order_id[wr_ptr] <= (state == GNT_D);
                wr_ptr           <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    assign s.req = (state != IDLE);

    // Request fields follow the granted master; in IDLE they are don't-care
    // because s.req is low.
    always_comb begin
        if (state == GNT_D) begin
            s.wr    = data.wr;
            s.size  = data.size;
            s.addr  = data.addr;
            s.wdata = data.wdata;
        end else begin
            s.wr    = inst.wr;
            s.size  = inst.size;
            s.addr  = inst.addr;
            s.wdata = inst.wdata;
        end
    end

    assign inst.addr_ok = (state == GNT_I) && s.addr_ok;
    assign data.addr_ok = (state == GNT_D) && s.addr_ok;

    assign inst.data_ok = pop && !head_id;
    assign data.data_ok = pop &&  head_id;

    assign inst.rdata = s.rdata;
    assign data.rdata = s.rdata;

endmodule
